// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, CDB, look-up, commit and status signals of the reorder buffer
// master = issue/RS/CDB side, slave = reorder_buffer
// alloc_*: issue request and tag, cdb*: two result buses, index/ready/value: operand look-up,
// flush: squash, commit_*: retired entry, count/empty/full: occupancy
interface reorder_buffer_if;
  logic        alloc_valid;
  logic        alloc_has_dest;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_rob_num;
  logic [31:0] cdb_data;
  logic        cdb_valid2;
  logic [5:0]  cdb_rob_num2;
  logic [31:0] cdb_data2;
  logic [5:0]  index;
  logic        ready;
  logic [31:0] value;
  logic        flush;
  logic        commit_valid;
  logic [5:0]  commit_tag;
  logic        commit_has_dest;
  logic [4:0]  commit_dest;
  logic [31:0] commit_data;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  modport master (
    output alloc_valid, alloc_has_dest, alloc_dest, cdb_valid, cdb_rob_num, cdb_data,
           cdb_valid2, cdb_rob_num2, cdb_data2, index, flush,
    input  alloc_ready, alloc_tag, ready, value, commit_valid, commit_tag, commit_has_dest,
           commit_dest, commit_data, count, empty, full
  );
  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_dest, cdb_valid, cdb_rob_num, cdb_data,
           cdb_valid2, cdb_rob_num2, cdb_data2, index, flush,
    output alloc_ready, alloc_tag, ready, value, commit_valid, commit_tag, commit_has_dest,
           commit_dest, commit_data, count, empty, full
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular ROB with dual-CDB capture, bypassed operand look-up, in-order retire
// clock: rising edge; reset: async active-low; rob: reorder_buffer_if slave port
module reorder_buffer #(
  parameter int ENTRIES = 16,
  parameter int TAG_W = 6,
  parameter logic [TAG_W-1:0] INVALID_TAG = TAG_W'(16)
) (
  input logic clock,
  input logic reset,
  reorder_buffer_if.slave rob
);
  localparam int PW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);
  localparam logic [TAG_W-1:0] NTAG = TAG_W'(ENTRIES);
  logic [ENTRIES-1:0] busy, done, has_dest;
  logic [4:0] dest [ENTRIES];
  logic [31:0] data [ENTRIES];
  logic [PW-1:0] head, tail, li, w1, w2;
  logic [CW-1:0] count;
  logic alloc_fire, commit_fire, cap1, cap2, hit1, hit2;
  logic commit_valid, commit_has_dest;
  logic [TAG_W-1:0] commit_tag;
  logic [4:0] commit_dest;
  logic [31:0] commit_data;
  assign rob.full = count == CW'(ENTRIES);
  assign rob.empty = count == '0;
  assign rob.alloc_ready = !rob.full && !rob.flush;
  assign rob.alloc_tag = TAG_W'(tail);
  assign rob.count = count;
  assign rob.commit_valid = commit_valid;
  assign rob.commit_tag = commit_tag;
  assign rob.commit_has_dest = commit_has_dest;
  assign rob.commit_dest = commit_dest;
  assign rob.commit_data = commit_data;
  always_comb begin
    w1 = rob.cdb_rob_num[PW-1:0];
    w2 = rob.cdb_rob_num2[PW-1:0];
    cap1 = rob.cdb_valid && rob.cdb_rob_num < NTAG && busy[w1] && !done[w1];
    cap2 = rob.cdb_valid2 && rob.cdb_rob_num2 < NTAG && busy[w2] && !done[w2];
    li = rob.index[PW-1:0];
    hit1 = rob.cdb_valid && rob.cdb_rob_num == rob.index;
    hit2 = rob.cdb_valid2 && rob.cdb_rob_num2 == rob.index;
    alloc_fire = rob.alloc_valid && rob.alloc_ready;
    commit_fire = busy[head] && done[head];
    rob.ready = rob.index < NTAG && busy[li] && (done[li] || hit1 || hit2);
    rob.value = !rob.ready ? '0 : hit1 ? rob.cdb_data : hit2 ? rob.cdb_data2 : data[li];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      busy <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      commit_valid <= 1'b0;
      commit_tag <= INVALID_TAG;
      commit_has_dest <= 1'b0;
      commit_dest <= '0;
      commit_data <= '0;
    end else if (rob.flush) begin
      busy <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      if (commit_fire) begin
        commit_tag <= TAG_W'(head);
        commit_has_dest <= has_dest[head];
        commit_dest <= dest[head];
        commit_data <= data[head];
        busy[head] <= 1'b0;
        head <= head + PW'(1);
      end
      if (cap2) done[w2] <= 1'b1;
      if (cap1) done[w1] <= 1'b1;
      // head==tail with a committing head means full, so alloc never collides with commit
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail <= tail + PW'(1);
      end
      count <= count + CW'(alloc_fire) - CW'(commit_fire);
    end
  // payload needs no reset: it is only observed through busy/done
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      has_dest[tail] <= rob.alloc_has_dest;
      dest[tail] <= rob.alloc_dest;
    end
    if (cap2) data[w2] <= rob.cdb_data2;
    if (cap1) data[w1] <= rob.cdb_data;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized and directed check of reorder_buffer against a queue-based model
module tb_reorder_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  reorder_buffer_if rif();
  reorder_buffer dut (.clock(clock), .reset(reset), .rob(rif));
  typedef struct packed {
    logic [5:0]  tag;
    logic        hd;
    logic [4:0]  dst;
    logic        dn;
    logic [31:0] dat;
  } ent_t;
  ent_t q[$];
  logic [5:0] log_tag[$];
  logic [31:0] log_dat[$];
  int mtail;
  logic e_cv, e_chd;
  logic [5:0] e_ct;
  logic [4:0] e_cd;
  logic [31:0] e_cdat;
  int tests = 0;
  int fails = 0;
  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", t, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mtail = 0;
    e_cv = 1'b0;
    e_ct = 6'd16;
    e_chd = 1'b0;
    e_cd = '0;
    e_cdat = '0;
  endtask
  task automatic idle();
    rif.alloc_valid = 1'b0;
    rif.alloc_has_dest = 1'b0;
    rif.alloc_dest = '0;
    rif.cdb_valid = 1'b0;
    rif.cdb_rob_num = '0;
    rif.cdb_data = '0;
    rif.cdb_valid2 = 1'b0;
    rif.cdb_rob_num2 = '0;
    rif.cdb_data2 = '0;
    rif.index = 6'd16;
    rif.flush = 1'b0;
  endtask
  task automatic cdb1(input logic [5:0] t, input logic [31:0] d);
    rif.cdb_valid = 1'b1;
    rif.cdb_rob_num = t;
    rif.cdb_data = d;
  endtask
  task automatic alloc(input logic [4:0] d);
    rif.alloc_valid = 1'b1;
    rif.alloc_has_dest = d[0];
    rif.alloc_dest = d;
  endtask
  task automatic check_all();
    int f;
    logic c1, c2, er;
    logic [31:0] ev;
    f = -1;
    c1 = rif.cdb_valid && rif.cdb_rob_num == rif.index;
    c2 = rif.cdb_valid2 && rif.cdb_rob_num2 == rif.index;
    foreach (q[i]) if (q[i].tag == rif.index) f = i;
    er = 1'b0;
    ev = '0;
    if (f >= 0) begin
      er = q[f].dn || c1 || c2;
      if (er) ev = c1 ? rif.cdb_data : c2 ? rif.cdb_data2 : q[f].dat;
    end
    check("alloc_ready", rif.alloc_ready, q.size() < 16 && !rif.flush);
    check("alloc_tag", rif.alloc_tag, 32'(mtail));
    check("count", rif.count, 32'(q.size()));
    check("empty", rif.empty, q.size() == 0);
    check("full", rif.full, q.size() == 16);
    check("ready", rif.ready, er);
    check("value", rif.value, ev);
    check("commit_valid", rif.commit_valid, e_cv);
    check("commit_tag", rif.commit_tag, e_ct);
    check("commit_has_dest", rif.commit_has_dest, e_chd);
    check("commit_dest", rif.commit_dest, e_cd);
    check("commit_data", rif.commit_data, e_cdat);
    if (rif.commit_valid) begin
      log_tag.push_back(rif.commit_tag);
      log_dat.push_back(rif.commit_data);
    end
  endtask
  task automatic model_step();
    logic a_ok, com;
    ent_t e;
    a_ok = q.size() < 16 && !rif.flush;
    com = q.size() > 0 && q[0].dn;
    if (rif.flush) begin
      q.delete();
      mtail = 0;
      e_cv = 1'b0;
    end else begin
      foreach (q[i])
        if (!q[i].dn) begin
          if (rif.cdb_valid && rif.cdb_rob_num == q[i].tag) begin
            q[i].dn = 1'b1;
            q[i].dat = rif.cdb_data;
          end else if (rif.cdb_valid2 && rif.cdb_rob_num2 == q[i].tag) begin
            q[i].dn = 1'b1;
            q[i].dat = rif.cdb_data2;
          end
        end
      e_cv = com;
      if (com) begin
        e_ct = q[0].tag;
        e_chd = q[0].hd;
        e_cd = q[0].dst;
        e_cdat = q[0].dat;
        void'(q.pop_front());
      end
      if (rif.alloc_valid && a_ok) begin
        e.tag = 6'(mtail);
        e.hd = rif.alloc_has_dest;
        e.dst = rif.alloc_dest;
        e.dn = 1'b0;
        e.dat = '0;
        q.push_back(e);
        mtail = (mtail + 1) % 16;
      end
    end
  endtask
  task automatic cycle();
    @(negedge clock);
    check_all();
    model_step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [5:0] pick_tag();
    if (q.size() > 0 && $urandom_range(0, 3) != 0) return q[$urandom_range(0, q.size() - 1)].tag;
    return 6'($urandom_range(0, 20));
  endfunction
  task automatic rand_inputs(input int cdb_pct);
    rif.alloc_valid = $urandom_range(0, 99) < 60;
    rif.alloc_has_dest = 1'($urandom);
    rif.alloc_dest = 5'($urandom);
    rif.cdb_valid = $urandom_range(0, 99) < cdb_pct;
    rif.cdb_rob_num = pick_tag();
    rif.cdb_data = $urandom;
    rif.cdb_valid2 = $urandom_range(0, 99) < cdb_pct;
    rif.cdb_rob_num2 = $urandom_range(0, 4) == 0 ? rif.cdb_rob_num : pick_tag();
    rif.cdb_data2 = $urandom;
    rif.index = $urandom_range(0, 3) == 0 ? rif.cdb_rob_num : pick_tag();
    rif.flush = $urandom_range(0, 99) < 2;
  endtask
  initial begin
    model_reset();
    idle();
    rif.index = 6'd3;
    #12;
    check("rst_alloc_tag", rif.alloc_tag, 0);
    check("rst_alloc_ready", rif.alloc_ready, 1);
    check("rst_empty", rif.empty, 1);
    check("rst_full", rif.full, 0);
    check("rst_count", rif.count, 0);
    check("rst_ready", rif.ready, 0);
    check("rst_value", rif.value, 0);
    check("rst_commit_valid", rif.commit_valid, 0);
    check("rst_commit_tag", rif.commit_tag, 16);
    check("rst_commit_has_dest", rif.commit_has_dest, 0);
    check("rst_commit_dest", rif.commit_dest, 0);
    check("rst_commit_data", rif.commit_data, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      alloc(5'(i + 1));
      cycle();
    end
    idle();
    #1;
    check("alloc3_count", rif.count, 3);
    check("alloc3_tag", rif.alloc_tag, 3);
    log_tag.delete();
    log_dat.delete();
    cdb1(6'd2, 32'h22);
    cycle();
    idle();
    cdb1(6'd0, 32'h0);
    cycle();
    idle();
    cdb1(6'd1, 32'h11);
    cycle();
    idle();
    repeat (4) cycle();
    check("ooo_commits", log_tag.size(), 3);
    if (log_tag.size() == 3) begin
      check("ooo_tag0", log_tag[0], 0);
      check("ooo_tag1", log_tag[1], 1);
      check("ooo_tag2", log_tag[2], 2);
      check("ooo_dat0", log_dat[0], 32'h0);
      check("ooo_dat1", log_dat[1], 32'h11);
      check("ooo_dat2", log_dat[2], 32'h22);
    end
    rif.flush = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 6; i++) begin
      alloc(5'(i + 7));
      cycle();
    end
    idle();
    rif.index = 6'd0;
    #1;
    check("pending_ready", rif.ready, 0);
    rif.index = 6'd16;
    #1;
    check("inv_ready", rif.ready, 0);
    check("inv_value", rif.value, 0);
    cdb1(6'd5, 32'hAAAA);
    rif.cdb_valid2 = 1'b1;
    rif.cdb_rob_num2 = 6'd5;
    rif.cdb_data2 = 32'hBBBB;
    rif.index = 6'd5;
    #1;
    check("dual_ready", rif.ready, 1);
    check("dual_value", rif.value, 32'hAAAA);
    cycle();
    idle();
    for (int t = 0; t < 5; t++) begin
      cdb1(6'(t), 32'(t * 256));
      cycle();
      idle();
    end
    repeat (4) cycle();
    check("dual_commit_tag", log_tag[$], 5);
    check("dual_commit_data", log_dat[$], 32'hAAAA);
    rif.flush = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i));
      cycle();
    end
    idle();
    #1;
    check("fill_full", rif.full, 1);
    check("fill_alloc_ready", rif.alloc_ready, 0);
    alloc(5'd31);
    cycle();
    idle();
    #1;
    check("over_count", rif.count, 16);
    check("over_tag", rif.alloc_tag, 0);
    cdb1(6'd0, 32'h77);
    cycle();
    idle();
    alloc(5'd9);
    #1;
    check("full_commit_refuse", rif.alloc_ready, 0);
    cycle();
    check("wrap_ready", rif.alloc_ready, 1);
    check("wrap_tag", rif.alloc_tag, 0);
    check("wrap_commit_valid", rif.commit_valid, 1);
    cycle();
    idle();
    #1;
    check("wrap_next_tag", rif.alloc_tag, 1);
    check("wrap_count", rif.count, 16);
    rif.flush = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      alloc(5'(i));
      cycle();
    end
    idle();
    cdb1(6'd0, 32'h99);
    alloc(5'd3);
    rif.flush = 1'b1;
    cycle();
    idle();
    check("flush_count", rif.count, 0);
    check("flush_cv", rif.commit_valid, 0);
    check("flush_tag", rif.alloc_tag, 0);
    cdb1(6'd1, 32'h5);
    cycle();
    idle();
    cycle();
    check("flush_stale_count", rif.count, 0);
    check("flush_stale_cv", rif.commit_valid, 0);
    for (int i = 0; i < 600; i++) begin
      rand_inputs(i < 300 ? 30 : 70);
      cycle();
    end
    idle();
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_count", rif.count, 0);
    check("mid_rst_cv", rif.commit_valid, 0);
    check("mid_rst_ctag", rif.commit_tag, 16);
    check("mid_rst_tag", rif.alloc_tag, 0);
    check("mid_rst_empty", rif.empty, 1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 150; i++) begin
      rand_inputs(50);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
